// File: rtl/fir_out_requant.sv
`default_nettype none
// ============================================================================
// Module   : fir_out_requant
// Brief    : FIR output stage. Captures the full-precision FIR result on the
//            ready strobe, rounds half toward +inf, arithmetic-shifts and
//            saturates it to OUT_W bits, then buffers it in a show-ahead
//            valid/ready FIFO. Flags clipping (pulse) and drops (sticky).
// Revision : 1.0 - initial release
// ============================================================================
module fir_out_requant #(
   parameter int IN_W       = 32,
   parameter int OUT_W      = 16,
   parameter int SHIFT      = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic [IN_W-1:0]               i_data,
   input  logic                          i_data_rdy,
   output logic [OUT_W-1:0]              o_data,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic                          o_sat,
   output logic                          o_overflow,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);

   localparam int AW = $clog2(FIFO_DEPTH);

   // Rounding constant 2^(SHIFT-1), held one bit wider than the input so the
   // add can never wrap.
   localparam logic signed [IN_W:0] RND   = $signed((IN_W+1)'(1) << (SHIFT-1));
   localparam logic signed [IN_W:0] Q_MAX = $signed(((IN_W+1)'(1) << (OUT_W-1)) - (IN_W+1)'(1));
   localparam logic signed [IN_W:0] Q_MIN = $signed(-Q_MAX - (IN_W+1)'(1));
   localparam logic [OUT_W-1:0]     S_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0]     S_MIN = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [AW:0]          C_FULL = (AW+1)'(FIFO_DEPTH);

   // ------------------------------------------------------------------
   // Stage 1: sign-extend and add the rounding constant
   // ------------------------------------------------------------------
   logic signed [IN_W:0] s1_d;
   logic signed [IN_W:0] s1_q;
   logic                 s1_v_q;

   assign s1_d = $signed({i_data[IN_W-1], i_data}) + RND;

   // Capture the rounded sum only when the FIR strobes a new result.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         s1_v_q <= 1'b0;
      end else begin
         s1_v_q <= i_data_rdy;
         if (i_data_rdy) begin
            s1_q <= s1_d;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: arithmetic shift and saturate to OUT_W
   // ------------------------------------------------------------------
   logic signed [IN_W:0] shifted;
   logic [OUT_W-1:0]     s2_d;
   logic                 s2_sat_d;
   logic [OUT_W-1:0]     s2_q;
   logic                 s2_sat_q;
   logic                 s2_v_q;

   assign shifted = s1_q >>> SHIFT;

   // Clamp the shifted value to the signed OUT_W range and flag clipping.
   always_comb begin
      s2_d     = shifted[OUT_W-1:0];
      s2_sat_d = 1'b0;
      if (shifted > Q_MAX) begin
         s2_d     = S_MAX;
         s2_sat_d = 1'b1;
      end else if (shifted < Q_MIN) begin
         s2_d     = S_MIN;
         s2_sat_d = 1'b1;
      end
   end

   // Register the requantised sample; data only moves when stage 1 is valid.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         s2_v_q   <= 1'b0;
         s2_sat_q <= 1'b0;
      end else begin
         s2_v_q <= s1_v_q;
         if (s1_v_q) begin
            s2_q     <= s2_d;
            s2_sat_q <= s2_sat_d;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 3: show-ahead FIFO
   // ------------------------------------------------------------------
   logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic [AW:0]      count_d;
   logic             ovf_q;
   logic             sat_q;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             push_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == C_FULL);
   assign push    = s2_v_q;
   assign pop     = !empty && i_ready;
   // A push into a full FIFO still lands if the head leaves on the same edge.
   assign push_ok = push && (!full || pop);

   // Occupancy follows the net of accepted pushes and pops.
   always_comb begin
      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage array is deliberately not reset; pointers and count gate its use.
   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= s2_q;
      end
   end

   // Pointers, occupancy and status flags.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         sat_q   <= push && s2_sat_q;
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push && !push_ok) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign o_valid    = !empty;
   assign o_data     = empty ? '0 : mem_q[rd_ptr_q];
   assign o_level    = count_q;
   assign o_sat      = sat_q;
   assign o_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_out_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_out_requant
// Brief    : Self-checking bench for fir_out_requant. Directed scenarios and
//            random traffic are checked every cycle against a queue-based
//            behavioural model of the requantiser and FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_out_requant;

   localparam int DEPTH = 4;
   localparam int SHIFT = 15;
   localparam int LAT   = 2;

   logic        clk;
   logic        i_reset;
   logic [31:0] i_data;
   logic        i_data_rdy;
   logic [15:0] o_data;
   logic        o_valid;
   logic        i_ready;
   logic        o_sat;
   logic        o_overflow;
   logic [2:0]  o_level;

   fir_out_requant #(
      .IN_W       (32),
      .OUT_W      (16),
      .SHIFT      (SHIFT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .i_clk      (clk),
      .i_reset    (i_reset),
      .i_data     (i_data),
      .i_data_rdy (i_data_rdy),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_sat      (o_sat),
      .o_overflow (o_overflow),
      .o_level    (o_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] v;
      bit          s;
      int          due;
   } pend_t;

   pend_t       pend[$];
   logic [15:0] fifo[$];
   logic [15:0] got[$];
   logic [15:0] exp_q[$];
   bit          ovf_m;
   bit          sat_m;
   int          ecnt;
   int          total;
   int          bad;

   // Reference requantiser: round half toward +inf, floor-shift, clamp.
   function automatic void ref_q(input logic [31:0] d, output logic [15:0] v, output bit s);
      longint x;
      x = longint'($signed(d)) + (longint'(1) << (SHIFT - 1));
      x = x >>> SHIFT;
      s = 1'b0;
      if (x > 32767) begin
         v = 16'h7FFF;
         s = 1'b1;
      end else if (x < -32768) begin
         v = 16'h8000;
         s = 1'b1;
      end else begin
         v = x[15:0];
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, then compare.
   task automatic cyc(input bit rst, input bit stb, input logic [31:0] d, input bit rdy);
      pend_t       p;
      logic [15:0] v;
      bit          s;
      bit          arr;
      bit          popm;
      bit          fullm;
      i_reset    = rst;
      i_data_rdy = stb;
      i_data     = stb ? d : $urandom;
      i_ready    = rdy;
      if (rdy && o_valid && !rst) got.push_back(o_data);
      @(posedge clk);
      ecnt++;
      if (rst) begin
         pend.delete();
         fifo.delete();
         ovf_m = 1'b0;
         sat_m = 1'b0;
      end else begin
         arr   = (pend.size() > 0) && (pend[0].due == ecnt);
         popm  = (fifo.size() > 0) && rdy;
         fullm = (fifo.size() == DEPTH);
         sat_m = 1'b0;
         if (popm) void'(fifo.pop_front());
         if (arr) begin
            p     = pend.pop_front();
            sat_m = p.s;
            if (!fullm || popm) fifo.push_back(p.v);
            else ovf_m = 1'b1;
         end
         if (stb) begin
            ref_q(d, v, s);
            pend.push_back('{v, s, ecnt + LAT});
         end
      end
      #1;
      chk("valid",    32'(o_valid),    32'(fifo.size() > 0));
      chk("level",    32'(o_level),    32'(fifo.size()));
      chk("data",     32'(o_data),     (fifo.size() > 0) ? 32'(fifo[0]) : 32'd0);
      chk("overflow", 32'(o_overflow), 32'(ovf_m));
      chk("sat",      32'(o_sat),      32'(sat_m));
   endtask

   task automatic chk_list(input string tag);
      chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         chk(tag, (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
      end
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] d;
      total      = 0;
      bad        = 0;
      ecnt       = 0;
      ovf_m      = 1'b0;
      sat_m      = 1'b0;
      i_reset    = 1'b1;
      i_data     = '0;
      i_data_rdy = 1'b0;
      i_ready    = 1'b0;

      // Reset state
      cyc(1, 0, 0, 0);
      cyc(1, 1, 32'h7FFF_FFFF, 1);
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_level", 32'(o_level), 0);

      // Rounding, consumer always ready
      got.delete();
      cyc(0, 1, 32'd32768, 1);
      cyc(0, 1, 32'd16384, 1);
      cyc(0, 1, 32'd16383, 1);
      cyc(0, 1, -32'sd16384, 1);
      cyc(0, 1, -32'sd16385, 1);
      cyc(0, 1, 32'd0, 1);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
      exp_q = '{16'd1, 16'd1, 16'd0, 16'd0, 16'hFFFF, 16'd0};
      chk_list("round");

      // Saturation
      got.delete();
      cyc(0, 1, 32'h7FFF_FFFF, 1);
      cyc(0, 1, 32'h8000_0000, 1);
      cyc(0, 1, 32'h3FFF_7FFF, 1);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
      exp_q = '{16'h7FFF, 16'h8000, 16'h7FFF};
      chk_list("sat_vals");

      // Latency: visible after the second edge following the strobe
      cyc(0, 1, 32'd5 << 15, 0);
      cyc(0, 0, 0, 0);
      chk("lat_early", 32'(o_valid), 0);
      cyc(0, 0, 0, 0);
      chk("lat_valid", 32'(o_valid), 1);
      chk("lat_level", 32'(o_level), 1);
      chk("lat_data",  32'(o_data),  5);
      cyc(0, 0, 0, 1);
      chk("lat_pop_valid", 32'(o_valid), 0);
      chk("lat_pop_data",  32'(o_data),  0);

      // Full / overflow
      for (int i = 1; i <= 5; i++) cyc(0, 1, 32'(i) << 15, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("full_level", 32'(o_level), 4);
      chk("full_ovf",   32'(o_overflow), 1);
      got.delete();
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
      exp_q = '{16'd1, 16'd2, 16'd3, 16'd4};
      chk_list("drain");
      chk("drain_ovf", 32'(o_overflow), 1);

      // Simultaneous push/pop at full
      cyc(1, 0, 0, 0);
      got.delete();
      for (int i = 1; i <= 6; i++) cyc(0, 1, 32'(i) << 15, 0);
      chk("pp_full", 32'(o_level), 4);
      for (int i = 7; i <= 16; i++) begin
         cyc(0, 1, 32'(i) << 15, 1);
         chk("pp_level", 32'(o_level), 4);
      end
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
      exp_q.delete();
      for (int i = 1; i <= 16; i++) exp_q.push_back(16'(i));
      chk_list("pp_order");
      chk("pp_ovf", 32'(o_overflow), 0);

      // Reset mid-stream: 3 in the FIFO, 2 in the pipeline
      for (int i = 1; i <= 4; i++) cyc(0, 1, 32'(i) << 15, 0);
      cyc(0, 1, 32'd5 << 15, 0);
      chk("mid_level", 32'(o_level), 3);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("mid_ovf_pre", 32'(o_overflow), 1);
      for (int i = 1; i <= 5; i++) cyc(1, 0, 0, 0);
      for (int i = 1; i <= 3; i++) cyc(0, 1, 32'(i) << 15, 0);
      cyc(0, 1, 32'd4 << 15, 0);
      cyc(0, 1, 32'd5 << 15, 0);
      cyc(1, 0, 0, 0);
      chk("mid_valid", 32'(o_valid), 0);
      chk("mid_level0", 32'(o_level), 0);
      chk("mid_ovf", 32'(o_overflow), 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         r = $urandom;
         case ($urandom_range(0, 2))
            0:       d = $urandom;
            1:       d = {{8{r[23]}}, r[23:0]};
            default: d = 32'h3FFF_7FFF + 32'($urandom_range(0, 65535)) - 32'd32768;
         endcase
         cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7), d,
             ($urandom_range(0, 9) < 5));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
